frame_buffer: RTL
=================

// Module: frame_buffer
// PURPOSE
//  1-bit 320x200 framebuffer between the game renderer (writer) and display_vga (reader).
//  Game writes pixels by (x,y); display_vga reads by (read_h>>1, read_v>>1) for 2x scan.
//  Contains a clear engine that fills the whole buffer with CLEAR_VAL on request.
//  Optional second bank, swapped at frame end.
// PARAMETERS
//  FB_W       320  pixels per line (x range 0..FB_W-1)
//  FB_H       200  lines (y range 0..FB_H-1)
//  CLEAR_VAL  1'b0 value written by the clear engine
// PORTS
//  clk         in   1   pixel-domain clock (2x VGA pixel rate)
//  rst_n       in   1   asynchronous active-low reset
//  rd_en       in   1   display read request
//  rd_x        in   9   read column
//  rd_y        in   8   read line
//  rd_pixel    out  1   read data, 1-cycle latency
//  wr_en       in   1   game write request
//  wr_x        in   9   write column
//  wr_y        in   8   write line
//  wr_pixel    in   1   write data
//  wr_ready    out  1   1 = write accepted this cycle
//  clear_req   in   1   1-cycle pulse: start full clear
//  clear_busy  out  1   1 while clear engine runs
//  frame_end   in   1   1-cycle pulse at end of active frame (swap point)
//  front_bank  out  1   bank currently read by display
// BEHAVIOUR
//  - Address = y*FB_W + x, 16 bit; in-range = x<FB_W && y<FB_H.
//  - Reset: rd_pixel=0, wr_ready=1, clear_busy=0, front_bank=0, FSM=IDLE, clear ctr=0.
//    RAM contents not reset.
//  - Read: rd_pixel registered; = mem[addr] one cycle after rd_en && in-range, else 0.
//  - Write: committed on the edge where wr_en && wr_ready && in-range.
//    Out-of-range writes are silently dropped.
//  - Read and write to same address in same cycle: read returns old data (read-first).
//  - FSM IDLE: wr_ready=1; clear_req -> CLEAR, ctr<=0.
//  - FSM CLEAR: writes CLEAR_VAL at ctr each cycle, ctr+1; clear_busy=1, wr_ready=0.
//    Game writes are dropped, not queued.
//  - CLEAR: ctr==FB_W*FB_H-1 -> last write, then IDLE next cycle.
//    Clear takes exactly FB_W*FB_H cycles (64000 by default).
//  - clear_req while CLEAR ignored (no restart).
//  - Reads remain serviced during CLEAR; they return whatever is stored.
//  - rst_n low mid-clear: abort to IDLE immediately; memory left partially cleared.
// CONFIGURATION
//  DOUBLE_BUFFER_EN defined: two banks.
//    - Reads use front_bank; writes and clear use ~front_bank.
//    - frame_end in IDLE toggles front_bank next edge.
//    - frame_end in CLEAR sets swap_pending; toggle happens on the CLEAR->IDLE edge.
//    - swap_pending cleared on toggle and by reset.
//    - frame_end coincident with clear_req in IDLE: swap first, then clear targets the
//      new back bank.
//  DOUBLE_BUFFER_EN undefined: single bank; frame_end ignored; front_bank tied 0.
// TESTING
//  1 Reset -> rd_pixel=0, wr_ready=1, clear_busy=0, front_bank=0.
//  2 Write (5,7)=1, then read (5,7) -> rd_pixel=1 exactly 1 cycle after rd_en;
//    read (6,7) -> value unchanged.
//  3 Write x=320 or y=200 -> no RAM change (check (0,0) and (0,1) unchanged).
//    Read (400,10) -> rd_pixel=0.
//  4 Pulse clear_req -> clear_busy high 64000 cycles, wr_ready low.
//    Write during clear dropped; afterwards every address reads 0.
//  5 Reset asserted at clear cycle 1000, then released -> clear_busy=0.
//    Addresses >=1000 keep old data.
//  6 DOUBLE_BUFFER_EN: write (1,1)=1, pulse frame_end -> front_bank=1, (1,1) reads 1.
//    frame_end during clear -> front_bank toggles on the clear-done edge.

Source files
------------

// File: rtl/frame_buffer_if.sv
// frame_buffer_if: pixel read/write, clear and bank-swap signals.
// Master drives requests; slave is the frame buffer.
interface frame_buffer_if;
    logic       rd_en;
    logic [8:0] rd_x;
    logic [7:0] rd_y;
    logic       rd_pixel;
    logic       wr_en;
    logic [8:0] wr_x;
    logic [7:0] wr_y;
    logic       wr_pixel;
    logic       wr_ready;
    logic       clear_req;
    logic       clear_busy;
    logic       frame_end;
    logic       front_bank;

    modport master (
        output rd_en, rd_x, rd_y,
        output wr_en, wr_x, wr_y, wr_pixel,
        output clear_req, frame_end,
        input  rd_pixel, wr_ready, clear_busy, front_bank
    );

    modport slave (
        input  rd_en, rd_x, rd_y,
        input  wr_en, wr_x, wr_y, wr_pixel,
        input  clear_req, frame_end,
        output rd_pixel, wr_ready, clear_busy, front_bank
    );
endinterface

// File: rtl/frame_buffer.sv
// frame_buffer: 1-bit FB_W x FB_H framebuffer with a full-clear engine.
// Define DOUBLE_BUFFER_EN for a second bank swapped at frame end.
module frame_buffer #(
    parameter int   FB_W      = 320,
    parameter int   FB_H      = 200,
    parameter logic CLEAR_VAL = 1'b0
) (
    input logic           clk,
    input logic           rst_n,
    frame_buffer_if.slave fb
);
    localparam int NPIX = FB_W * FB_H;
`ifdef DOUBLE_BUFFER_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif
    localparam int          AW   = $clog2(NB * NPIX);
    localparam logic [15:0] LAST = 16'(NPIX - 1);
    localparam logic [8:0]  W9   = 9'(FB_W);
    localparam logic [7:0]  H8   = 8'(FB_H);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t      state_q;
    logic [15:0] ctr_q;
    logic        rd_pixel_q;
    logic        wr_ready_q;
    logic        clear_busy_q;
    logic        rd_bank;
    logic        wr_bank;

    logic        mem_q [NB*NPIX];
    logic        mem_we;
    logic [AW-1:0] mem_wa;
    logic        mem_wd;

    logic        rd_in;
    logic        wr_in;
    logic [15:0] rd_addr;
    logic [15:0] wr_addr;

    // Banks are laid out back to back in one flat array.
    function automatic logic [AW-1:0] idx(input logic bank,
                                          input logic [15:0] a);
        return AW'(a) + (bank ? AW'(NPIX) : '0);
    endfunction

    assign rd_in   = (fb.rd_x < W9) && (fb.rd_y < H8);
    assign wr_in   = (fb.wr_x < W9) && (fb.wr_y < H8);
    assign rd_addr = 16'(fb.rd_y) * 16'(FB_W) + 16'(fb.rd_x);
    assign wr_addr = 16'(fb.wr_y) * 16'(FB_W) + 16'(fb.wr_x);

`ifdef DOUBLE_BUFFER_EN
    logic front_bank_q;
    logic swap_pend_q;
    assign rd_bank       = front_bank_q;
    assign wr_bank       = ~front_bank_q;
    assign fb.front_bank = front_bank_q;
`else
    logic unused_frame_end;
    assign unused_frame_end = fb.frame_end;
    assign rd_bank          = 1'b0;
    assign wr_bank          = 1'b0;
    assign fb.front_bank    = 1'b0;
`endif

    assign fb.rd_pixel   = rd_pixel_q;
    assign fb.wr_ready   = wr_ready_q;
    assign fb.clear_busy = clear_busy_q;

    always_comb begin
        mem_we = 1'b0;
        mem_wa = '0;
        mem_wd = 1'b0;
        if (state_q == CLEAR) begin
            mem_we = 1'b1;
            mem_wa = idx(wr_bank, ctr_q);
            mem_wd = CLEAR_VAL;
        end else if (fb.wr_en && wr_ready_q && wr_in) begin
            mem_we = 1'b1;
            mem_wa = idx(wr_bank, wr_addr);
            mem_wd = fb.wr_pixel;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_wa] <= mem_wd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ctr_q        <= '0;
            rd_pixel_q   <= 1'b0;
            wr_ready_q   <= 1'b1;
            clear_busy_q <= 1'b0;
`ifdef DOUBLE_BUFFER_EN
            front_bank_q <= 1'b0;
            swap_pend_q  <= 1'b0;
`endif
        end else begin
            rd_pixel_q <= (fb.rd_en && rd_in) ?
                          mem_q[idx(rd_bank, rd_addr)] : 1'b0;
            unique case (state_q)
                IDLE: begin
`ifdef DOUBLE_BUFFER_EN
                    if (fb.frame_end) front_bank_q <= ~front_bank_q;
`endif
                    if (fb.clear_req) begin
                        state_q      <= CLEAR;
                        ctr_q        <= '0;
                        wr_ready_q   <= 1'b0;
                        clear_busy_q <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (ctr_q == LAST) begin
                        state_q      <= IDLE;
                        wr_ready_q   <= 1'b1;
                        clear_busy_q <= 1'b0;
`ifdef DOUBLE_BUFFER_EN
                        // A swap seen during the clear lands on the exit edge.
                        if (swap_pend_q || fb.frame_end)
                            front_bank_q <= ~front_bank_q;
                        swap_pend_q <= 1'b0;
`endif
                    end else begin
                        ctr_q <= ctr_q + 16'd1;
`ifdef DOUBLE_BUFFER_EN
                        if (fb.frame_end) swap_pend_q <= 1'b1;
`endif
                    end
                end
            endcase
        end
    end
endmodule
